rank_classifier: RTL and testbench

RANK_CLASSIFIER -- requirements
Module: rank_classifier

---
 rtl/rank_classifier.sv | 178 +++++++++++++++++
 tb/tb_rank_classifier.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rank_classifier.sv
// ============================================================================
//  Module      : rank_classifier
//  Description : Sequential minimum search over NUM_RANKS XOR mismatch scores.
//                Captures all scores on a strobe, scans one per cycle, and
//                reports the winning rank, its score, a reject flag and,
//                optionally, the margin to the second-best score.
//  Options     : define RANK_CLASSIFIER_MARGIN_EN to build the second-best
//                tracker and a live margin output (otherwise margin is 0).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rank_classifier #(
    parameter int NUM_RANKS     = 13,
    parameter int SCORE_W       = 11,
    parameter int REJECT_THRESH = 400
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RANKS*SCORE_W-1:0] scores,
    input  logic                         scores_valid,
    output logic                         busy,
    output logic                         rank_valid,
    output logic [3:0]                   rank_id,
    output logic [SCORE_W-1:0]           best_score,
    output logic                         rank_none,
    output logic [SCORE_W-1:0]           margin,
    output logic                         dropped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]         LAST_IDX = 4'(NUM_RANKS - 1);
    localparam logic [SCORE_W-1:0] THRESH   = SCORE_W'(REJECT_THRESH);

    state_t               state_q;
    logic [3:0]           idx_q;
    logic [SCORE_W-1:0]   scores_q [NUM_RANKS];
    logic [SCORE_W-1:0]   min_q,  min_d;
    logic [3:0]           min_idx_q, min_idx_d;
    logic                 busy_q;
    logic                 rank_valid_q;
    logic [3:0]           rank_id_q;
    logic [SCORE_W-1:0]   best_q;
    logic                 none_q;
    logic                 dropped_q;
    logic [SCORE_W-1:0]   cur_score;
    logic                 accept;

    // A strobe is only honoured when idle; reset wins over a same-cycle strobe.
    assign accept    = rst_n && (state_q == IDLE) && scores_valid;
    assign cur_score = scores_q[idx_q];

    // Snapshot of the score vector, frozen for the whole scan.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_RANKS; i++) begin
                scores_q[i] <= scores[i*SCORE_W +: SCORE_W];
            end
        end
    end

    // Running-minimum update for the score selected by idx; ties keep the lower index.
    always_comb begin
        min_d     = min_q;
        min_idx_d = min_idx_q;
        if (idx_q == 4'd0) begin
            min_d     = cur_score;
            min_idx_d = 4'd0;
        end else if (cur_score < min_q) begin
            min_d     = cur_score;
            min_idx_d = idx_q;
        end
    end

`ifdef RANK_CLASSIFIER_MARGIN_EN
    logic [SCORE_W-1:0] sec_q, sec_d;
    logic [SCORE_W-1:0] margin_q;

    // Second-best tracker: a new minimum demotes the old one, else keep the smaller.
    always_comb begin
        sec_d = sec_q;
        if (idx_q == 4'd0) begin
            sec_d = '1;
        end else if (cur_score < min_q) begin
            sec_d = min_q;
        end else if (cur_score < sec_q) begin
            sec_d = cur_score;
        end
    end

    // Second-best and margin registers; margin loads only on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_q    <= '0;
            margin_q <= '0;
        end else if (state_q == SCAN) begin
            sec_q <= sec_d;
            if (idx_q == LAST_IDX) begin
                margin_q <= sec_d - min_d;
            end
        end
    end

    assign margin = margin_q;
`else
    assign margin = '0;
`endif

    // Control FSM with registered result outputs and sticky drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            busy_q       <= 1'b0;
            rank_valid_q <= 1'b0;
            rank_id_q    <= 4'd0;
            best_q       <= '0;
            none_q       <= 1'b1;
            dropped_q    <= 1'b0;
            min_q        <= '0;
            min_idx_q    <= 4'd0;
        end else begin
            rank_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (scores_valid) begin
                        state_q <= SCAN;
                        idx_q   <= 4'd0;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (scores_valid) begin
                        dropped_q <= 1'b1;
                    end
                    min_q     <= min_d;
                    min_idx_q <= min_idx_d;
                    idx_q     <= idx_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_q      <= DONE;
                        rank_valid_q <= 1'b1;
                        rank_id_q    <= min_idx_d;
                        best_q       <= min_d;
                        none_q       <= (min_d > THRESH);
                    end
                end
                DONE: begin
                    if (scores_valid) begin
                        dropped_q <= 1'b1;
                    end
                    state_q <= IDLE;
                    idx_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign rank_valid = rank_valid_q;
    assign rank_id    = rank_id_q;
    assign best_score = best_q;
    assign rank_none  = none_q;
    assign dropped    = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_rank_classifier.sv
// ============================================================================
//  Module      : tb_rank_classifier
//  Description : Directed self-checking bench for rank_classifier. Honours
//                RANK_CLASSIFIER_MARGIN_EN for the expected margin values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rank_classifier;

    localparam int NR  = 13;
    localparam int SW  = 11;
    localparam int THR = 400;
`ifdef RANK_CLASSIFIER_MARGIN_EN
    localparam int MEN = 1;
`else
    localparam int MEN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR*SW-1:0]  scores_in = '0;
    logic [NR*SW-1:0]  alt_scores = '0;
    logic              scores_valid = 1'b0;
    logic              busy;
    logic              rank_valid;
    logic [3:0]        rank_id;
    logic [SW-1:0]     best_score;
    logic              rank_none;
    logic [SW-1:0]     margin;
    logic              dropped;

    rank_classifier #(
        .NUM_RANKS     (NR),
        .SCORE_W       (SW),
        .REJECT_THRESH (THR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scores       (scores_in),
        .scores_valid (scores_valid),
        .busy         (busy),
        .rank_valid   (rank_valid),
        .rank_id      (rank_id),
        .best_score   (best_score),
        .rank_none    (rank_none),
        .margin       (margin),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Results gathered by classify()
    int            pulses, first_k, second_k;
    logic          busy_k1, busy_after;
    logic [3:0]    hold_id;
    logic [3:0]    p_id   [2];
    logic [SW-1:0] p_best [2];
    logic          p_none [2];
    logic [SW-1:0] p_marg [2];
    logic          s_busy, s_valid, s_none, s_drop;
    logic [3:0]    s_id;
    logic [SW-1:0] s_best, s_marg;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < NR; i++) scores_in[i*SW +: SW] = SW'(v);
    endtask

    task automatic set_rank(input int i, input int v);
        scores_in[i*SW +: SW] = SW'(v);
    endtask

    // Strobe at edge T, then observe `window` edges. k counts edges after T,
    // so k == NR means rank_valid is visible during cycle T+NR+1.
    // kind 1: extra strobe with alt_scores sampled at edge T+inj_at.
    // kind 2: reset sampled at edge T+inj_at.
    task automatic classify(input int inj_at, input int kind, input int window);
        pulses = 0; first_k = -1; second_k = -1;
        busy_k1 = 1'b0; busy_after = 1'b1; hold_id = 4'hF;
        @(posedge clk); #1 scores_valid = 1'b1;
        @(posedge clk); #1 scores_valid = 1'b0;
        for (int k = 1; k <= window; k++) begin
            @(posedge clk); #1;
            if (rank_valid) begin
                if (pulses < 2) begin
                    p_id[pulses]   = rank_id;
                    p_best[pulses] = best_score;
                    p_none[pulses] = rank_none;
                    p_marg[pulses] = margin;
                end
                if (pulses == 0) first_k = k;
                else if (pulses == 1) second_k = k;
                pulses++;
            end
            if (k == 1) busy_k1 = busy;
            if (k == NR + 1) busy_after = busy;
            if (k == 20) hold_id = rank_id;
            if (k == 2) scores_in = '0;   // input changes must not leak into the scan
            if (kind != 0 && k == inj_at) begin
                s_busy = busy; s_valid = rank_valid; s_id = rank_id; s_best = best_score;
                s_none = rank_none; s_marg = margin; s_drop = dropped;
                scores_valid = 1'b0;
                rst_n = 1'b1;
            end
            if (kind != 0 && k == inj_at - 1) begin
                if (kind == 1) begin
                    scores_in    = alt_scores;
                    scores_valid = 1'b1;
                end else begin
                    rst_n = 1'b0;
                end
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   busy, 0);
        check("rst_valid",  rank_valid, 0);
        check("rst_id",     rank_id, 0);
        check("rst_best",   best_score, 0);
        check("rst_none",   rank_none, 1);
        check("rst_margin", margin, 0);
        check("rst_drop",   dropped, 0);
        rst_n = 1'b1;

        // Single clear winner at rank 7
        set_all(500); set_rank(7, 120);
        classify(0, 0, 20);
        check("s1_pulses",  pulses, 1);
        check("s1_latency", first_k, NR);
        check("s1_busy1",   busy_k1, 1);
        check("s1_busyend", busy_after, 0);
        check("s1_id",      p_id[0], 7);
        check("s1_best",    p_best[0], 120);
        check("s1_none",    p_none[0], 0);
        check("s1_margin",  p_marg[0], MEN ? 380 : 0);
        check("s1_hold_id", rank_id, 7);

        // Tie between ranks 3 and 9 -> lower index
        set_all(900); set_rank(3, 50); set_rank(9, 50);
        classify(0, 0, 16);
        check("s2_id",     p_id[0], 3);
        check("s2_best",   p_best[0], 50);
        check("s2_margin", p_marg[0], 0);

        // Reject boundary: 401 rejected, 400 accepted
        set_all(401);
        classify(0, 0, 16);
        check("s3a_id",   p_id[0], 0);
        check("s3a_best", p_best[0], 401);
        check("s3a_none", p_none[0], 1);
        set_all(400);
        classify(0, 0, 16);
        check("s3b_best", p_best[0], 400);
        check("s3b_none", p_none[0], 0);

        // Back-to-back strobes at T and T+15
        set_all(500); set_rank(7, 120);
        for (int i = 0; i < NR; i++) alt_scores[i*SW +: SW] = SW'(300);
        alt_scores[11*SW +: SW] = SW'(10);
        classify(15, 1, 32);
        check("s4_pulses",  pulses, 2);
        check("s4_first",   first_k, NR);
        check("s4_second",  second_k, NR + 15);
        check("s4_hold",    hold_id, 7);
        check("s4_id1",     p_id[0], 7);
        check("s4_id2",     p_id[1], 11);
        check("s4_best2",   p_best[1], 10);
        check("s4_margin2", p_marg[1], MEN ? 290 : 0);
        check("s4_drop",    dropped, 0);

        // Strobe during SCAN is dropped
        set_all(500); set_rank(7, 120);
        alt_scores = '0;
        classify(5, 1, 24);
        check("s5_pulses", pulses, 1);
        check("s5_id",     p_id[0], 7);
        check("s5_best",   p_best[0], 120);
        check("s5_drop",   dropped, 1);

        // Reset mid-scan at T+8
        set_all(500); set_rank(2, 30);
        classify(8, 2, 20);
        check("s6_pulses", pulses, 0);
        check("s6_busy",   s_busy, 0);
        check("s6_valid",  s_valid, 0);
        check("s6_id",     s_id, 0);
        check("s6_best",   s_best, 0);
        check("s6_none",   s_none, 1);
        check("s6_margin", s_marg, 0);
        check("s6_drop",   s_drop, 0);

        // Normal classification after the aborted scan
        set_all(700); set_rank(12, 200); set_rank(5, 260);
        classify(0, 0, 16);
        check("s7_latency", first_k, NR);
        check("s7_id",      p_id[0], 12);
        check("s7_best",    p_best[0], 200);
        check("s7_margin",  p_marg[0], MEN ? 60 : 0);
        check("s7_drop",    dropped, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
